// File: rtl/shared_buffer_arbiter.sv
// shared_buffer_arbiter
// Four-way arbiter for the single-port shared SRAM. The host (requester 0) has
// strict priority, requesters 1..3 rotate round-robin, and an owner may lock the
// SRAM for a bounded burst. Grants are combinational. Read data is returned one
// cycle after the grant, tagged by a registered per-requester valid strobe.
module shared_buffer_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 128,
    parameter int MAX_LOCK = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [3:0]            req,
    input  logic [3:0]            lock,
    input  logic [3:0]            we,
    input  logic [4*ADDR_W-1:0]   addr,
    input  logic [4*DATA_W-1:0]   wdata,
    output logic [3:0]            gnt,
    output logic [3:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  sram_cen,
    output logic                  sram_wen,
    output logic [ADDR_W-1:0]     sram_a,
    output logic [DATA_W-1:0]     sram_d,
    input  logic [DATA_W-1:0]     sram_q,
    output logic [1:0]            owner,
    output logic                  locked
);

    localparam int CNT_W = $clog2(MAX_LOCK) + 1;
    localparam logic [CNT_W-1:0] LP_MAX_CNT = CNT_W'(MAX_LOCK);

    localparam logic ST_ARB    = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    logic               r_state;
    logic [1:0]         r_owner;
    logic [1:0]         r_rr_ptr;
    logic [CNT_W-1:0]   r_lock_cnt;
    logic               r_excl;
    logic [3:0]         r_rvalid;
    logic [ADDR_W-1:0]  r_last_a;
    logic [DATA_W-1:0]  r_last_d;

    logic [3:0]         w_req_arb;
    logic [1:0]         w_o0, w_o1, w_o2;
    logic               w_arb_valid;
    logic [1:0]         w_arb_idx;
    logic               w_hold;
    logic [1:0]         w_win;
    logic               w_any;
    logic [3:0]         w_gnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_cnt_max;

    // Round-robin search order over requesters 1..3, starting at r_rr_ptr.
    always_comb begin
        w_o0 = 2'd1;
        w_o1 = 2'd2;
        w_o2 = 2'd3;
        case (r_rr_ptr)
            2'd2: begin w_o0 = 2'd2; w_o1 = 2'd3; w_o2 = 2'd1; end
            2'd3: begin w_o0 = 2'd3; w_o1 = 2'd1; w_o2 = 2'd2; end
            default: ;
        endcase
    end

    // Free arbitration: host first, then rotating order; a just-expired lock owner sits out one cycle.
    always_comb begin
        w_req_arb   = r_excl ? (req & ~(4'b0001 << r_owner)) : req;
        w_arb_valid = 1'b1;
        w_arb_idx   = 2'd0;
        if (w_req_arb[0])         w_arb_idx = 2'd0;
        else if (w_req_arb[w_o0]) w_arb_idx = w_o0;
        else if (w_req_arb[w_o1]) w_arb_idx = w_o1;
        else if (w_req_arb[w_o2]) w_arb_idx = w_o2;
        else                      w_arb_valid = 1'b0;
    end

    // Winner select: a locked owner that still requests overrides free arbitration.
    always_comb begin
        w_hold    = (r_state == ST_LOCKED) && req[r_owner];
        w_win     = w_hold ? r_owner : w_arb_idx;
        w_any     = RESET && (w_hold || w_arb_valid);
        w_gnt     = w_any ? (4'b0001 << w_win) : 4'b0000;
        w_cnt_inc = (r_lock_cnt == '1) ? r_lock_cnt : r_lock_cnt + 1'b1;
        w_cnt_max = (w_cnt_inc >= LP_MAX_CNT);
    end

    assign gnt      = w_gnt;
    assign rvalid   = r_rvalid;
    assign rdata    = sram_q;
    assign sram_cen = ~w_any;
    assign sram_wen = w_any ? ~we[w_win] : 1'b1;
    assign sram_a   = w_any ? addr[w_win*ADDR_W +: ADDR_W]  : r_last_a;
    assign sram_d   = w_any ? wdata[w_win*DATA_W +: DATA_W] : r_last_d;
    assign owner    = r_owner;
    assign locked   = (r_state == ST_LOCKED);

    // Arbitration state: lock FSM, owner, round-robin pointer, burst counter, forced-gap flag.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= ST_ARB;
            r_owner    <= 2'd0;
            r_rr_ptr   <= 2'd1;
            r_lock_cnt <= '0;
            r_excl     <= 1'b0;
        end else if (w_hold) begin
            r_excl     <= 1'b0;
            r_lock_cnt <= w_cnt_inc;
            if (!lock[r_owner] || w_cnt_max) begin
                r_state    <= ST_ARB;
                r_lock_cnt <= '0;
                r_excl     <= w_cnt_max;
            end
        end else begin
            // Covers plain ARB cycles and LOCKED cycles where the owner dropped req.
            r_excl <= 1'b0;
            if (w_arb_valid) begin
                r_owner <= w_arb_idx;
                if (w_arb_idx != 2'd0)
                    r_rr_ptr <= (w_arb_idx == 2'd3) ? 2'd1 : w_arb_idx + 2'd1;
                if (lock[w_arb_idx]) begin
                    r_state    <= ST_LOCKED;
                    r_lock_cnt <= CNT_W'(1);
                end else begin
                    r_state    <= ST_ARB;
                    r_lock_cnt <= '0;
                end
            end else begin
                r_state    <= ST_ARB;
                r_lock_cnt <= '0;
            end
        end
    end

    // Read-return tag and idle hold values for the SRAM address/data pins.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rvalid <= '0;
            r_last_a <= '0;
            r_last_d <= '0;
        end else begin
            r_rvalid <= (w_any && !we[w_win]) ? w_gnt : 4'b0000;
            if (w_any) begin
                r_last_a <= addr[w_win*ADDR_W +: ADDR_W];
                r_last_d <= wdata[w_win*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_shared_buffer_arbiter.sv
// tb_shared_buffer_arbiter
// Directed checks of shared_buffer_arbiter against hand-computed grant sequences,
// followed by a randomized phase checking grant/rvalid/host-latency properties.
module tb_shared_buffer_arbiter;

    localparam int AW = 13;
    localparam int DW = 128;
    localparam int ML = 16;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic [3:0]        req, lock, we;
    logic [4*AW-1:0]   addr;
    logic [4*DW-1:0]   wdata;
    logic [3:0]        gnt, rvalid;
    logic [DW-1:0]     rdata;
    logic              sram_cen, sram_wen;
    logic [AW-1:0]     sram_a;
    logic [DW-1:0]     sram_d;
    logic [DW-1:0]     sram_q = '0;
    logic [1:0]        owner;
    logic              locked;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mem [int];
    localparam logic [DW-1:0] A5 = {16{8'hA5}};

    shared_buffer_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .CLK(CLK), .RESET(RESET), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a), .sram_d(sram_d),
        .sram_q(sram_q), .owner(owner), .locked(locked)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {8{a, 3'b101}};
    endfunction

    // SRAM macro model: one-cycle read latency, unwritten words read as pat(addr).
    always @(posedge CLK) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[int'(sram_a)] = sram_d;
            else sram_q <= mem.exists(int'(sram_a)) ? mem[int'(sram_a)] : pat(sram_a);
        end
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_port(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    logic [3:0] exp4 [9];
    logic [3:0] req_h, lk_h, exp_rv;
    logic       host_pend;
    int         host_wait;

    initial begin
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;

        // Reset state
        tick(); tick(); settle();
        check_val("rst_gnt",    128'(gnt), 128'(4'b0000));
        check_val("rst_rvalid", 128'(rvalid), 128'(4'b0000));
        check_val("rst_cen",    128'(sram_cen), 128'(1'b1));
        check_val("rst_wen",    128'(sram_wen), 128'(1'b1));
        check_val("rst_a",      128'(sram_a), 128'(0));
        check_val("rst_d",      128'(sram_d), 128'(0));
        check_val("rst_owner",  128'(owner), 128'(0));
        check_val("rst_locked", 128'(locked), 128'(0));
        RESET = 1'b1;

        // Test 1: requesters 1 and 2 read; rr_ptr=1 picks 1 first
        tick();
        set_port(1, 13'h011, '0); set_port(2, 13'h022, '0);
        req = 4'b0110; we = 4'b0000; settle();
        check_val("t1_gnt1", 128'(gnt), 128'(4'b0010));
        check_val("t1_cen",  128'(sram_cen), 128'(1'b0));
        check_val("t1_wen",  128'(sram_wen), 128'(1'b1));
        check_val("t1_a1",   128'(sram_a), 128'(13'h011));
        tick(); req = 4'b0100; settle();
        check_val("t1_gnt2", 128'(gnt), 128'(4'b0100));
        check_val("t1_rv1",  128'(rvalid), 128'(4'b0010));
        check_val("t1_rd1",  rdata, pat(13'h011));
        check_val("t1_a2",   128'(sram_a), 128'(13'h022));
        tick(); req = 4'b0000; settle();
        check_val("t1_idle", 128'(gnt), 128'(4'b0000));
        check_val("t1_rv2",  128'(rvalid), 128'(4'b0100));
        check_val("t1_rd2",  rdata, pat(13'h022));
        check_val("t1_hold", 128'(sram_a), 128'(13'h022));
        check_val("t1_cen1", 128'(sram_cen), 128'(1'b1));
        check_val("t1_own",  128'(owner), 128'(2));

        // Test 2: host write beats waiting requester 3
        tick();
        set_port(0, 13'h040, A5); set_port(3, 13'h123, '0);
        req = 4'b1001; we = 4'b0001; settle();
        check_val("t2_gnt0", 128'(gnt), 128'(4'b0001));
        check_val("t2_cen",  128'(sram_cen), 128'(1'b0));
        check_val("t2_wen",  128'(sram_wen), 128'(1'b0));
        check_val("t2_a",    128'(sram_a), 128'(13'h040));
        check_val("t2_d",    sram_d, A5);
        tick(); req = 4'b1000; we = 4'b0000; settle();
        check_val("t2_gnt3", 128'(gnt), 128'(4'b1000));
        check_val("t2_a3",   128'(sram_a), 128'(13'h123));
        check_val("t2_norv", 128'(rvalid), 128'(4'b0000));
        tick(); req = 4'b0001; settle();
        check_val("t2_gnth", 128'(gnt), 128'(4'b0001));
        check_val("t2_rv3",  128'(rvalid), 128'(4'b1000));
        check_val("t2_rd3",  rdata, pat(13'h123));
        tick(); req = 4'b0000; settle();
        check_val("t2_rvh",  128'(rvalid), 128'(4'b0001));
        check_val("t2_rdh",  rdata, A5);

        // Test 4: host for three cycles, then rotation 1,2,3,1,2,3
        exp4 = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 4; i++) set_port(i, AW'(13'h200 + i), '0);
        for (int i = 0; i < 9; i++) begin
            tick();
            req = (i < 3) ? 4'b1111 : 4'b1110; we = 4'b0000; settle();
            check_val($sformatf("t4_gnt%0d", i), 128'(gnt), 128'(exp4[i]));
            check_val($sformatf("t4_rv%0d", i), 128'(rvalid), 128'((i == 0) ? 4'b0000 : exp4[i-1]));
        end
        tick(); req = 4'b0000; settle();
        check_val("t4_rvlast", 128'(rvalid), 128'(4'b1000));

        // Test 3: requester 2 locked burst of 20 with host waiting
        tick();
        set_port(0, 13'h1FFF, '0); set_port(2, 13'h100, '0);
        req = 4'b0100; lock = 4'b0100; we = 4'b0000; settle();
        check_val("t3_gnt_b0", 128'(gnt), 128'(4'b0100));
        check_val("t3_unlk",   128'(locked), 128'(0));
        for (int k = 1; k < 16; k++) begin
            tick();
            set_port(2, AW'(13'h100 + k), '0); req = 4'b0101; settle();
            check_val($sformatf("t3_gnt_b%0d", k), 128'(gnt), 128'(4'b0100));
            check_val($sformatf("t3_rv_b%0d", k), 128'(rvalid), 128'(4'b0100));
            check_val($sformatf("t3_rd_b%0d", k), rdata, pat(AW'(13'h100 + k - 1)));
            if (k == 1 || k == 15) check_val($sformatf("t3_lk_b%0d", k), 128'(locked), 128'(1));
        end
        tick(); set_port(2, 13'h110, '0); req = 4'b0101; settle();
        check_val("t3_gap_host", 128'(gnt), 128'(4'b0001));
        check_val("t3_gap_unlk", 128'(locked), 128'(0));
        check_val("t3_gap_rd",   rdata, pat(13'h10F));
        tick(); req = 4'b0100; settle();
        check_val("t3_rearb",  128'(gnt), 128'(4'b0100));
        check_val("t3_rv_h",   128'(rvalid), 128'(4'b0001));
        check_val("t3_rd_h",   rdata, pat(13'h1FFF));
        for (int c = 18; c < 21; c++) begin
            tick(); set_port(2, AW'(13'h110 + c - 17), '0); req = 4'b0100; settle();
            check_val($sformatf("t3_gnt_c%0d", c), 128'(gnt), 128'(4'b0100));
            check_val($sformatf("t3_rd_c%0d", c), rdata, pat(AW'(13'h110 + c - 18)));
        end
        tick(); set_port(1, 13'h300, '0); req = 4'b0010; lock = 4'b0000; settle();
        check_val("t3_exit_lk",  128'(locked), 128'(1));
        check_val("t3_exit_gnt", 128'(gnt), 128'(4'b0010));
        check_val("t3_exit_rd",  rdata, pat(13'h113));
        tick(); req = 4'b0000; settle();
        check_val("t3_post_lk",  128'(locked), 128'(0));
        check_val("t3_post_rv",  128'(rvalid), 128'(4'b0010));
        check_val("t3_post_rd",  rdata, pat(13'h300));

        // Test 5: reset asserted during a granted locked read
        tick(); set_port(3, 13'h0AA, '0); req = 4'b1000; lock = 4'b1000; settle();
        check_val("t5_gnt", 128'(gnt), 128'(4'b1000));
        #1 RESET = 1'b0;
        #1;
        check_val("t5_rst_gnt", 128'(gnt), 128'(4'b0000));
        check_val("t5_rst_cen", 128'(sram_cen), 128'(1'b1));
        check_val("t5_rst_own", 128'(owner), 128'(0));
        check_val("t5_rst_a",   128'(sram_a), 128'(0));
        tick(); settle();
        check_val("t5_rst_rv",  128'(rvalid), 128'(4'b0000));
        check_val("t5_rst_lk",  128'(locked), 128'(0));
        RESET = 1'b1;
        set_port(1, 13'h0BB, '0); req = 4'b1010; lock = 4'b0000; settle();
        check_val("t5_rr_gnt", 128'(gnt), 128'(4'b0010));
        tick(); req = 4'b0000; settle();
        check_val("t5_rv",  128'(rvalid), 128'(4'b0010));
        check_val("t5_rd",  rdata, pat(13'h0BB));

        // Randomized phase: structural properties and host latency bound
        req_h = '0; lk_h = '0; host_pend = 1'b0; host_wait = 0; exp_rv = 4'b0000;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (!host_pend) host_pend = ($urandom_range(0, 3) == 0);
            for (int k = 1; k < 4; k++) begin
                if (req_h[k]) begin
                    if ($urandom_range(0, 15) == 0) req_h[k] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req_h[k] = 1'b1;
                    lk_h[k]  = ($urandom_range(0, 1) == 1);
                end
            end
            req  = {req_h[3:1], host_pend};
            lock = {lk_h[3:1], ($urandom_range(0, 3) == 0)};
            we   = 4'($urandom_range(0, 15));
            addr = 52'({$urandom(), $urandom()});
            settle();
            check_val("rnd_onehot", 128'($countones(gnt) <= 1), 128'(1));
            check_val("rnd_gnt_req", 128'(gnt & ~req), 128'(0));
            check_val("rnd_rvalid", 128'(rvalid), 128'(exp_rv));
            check_val("rnd_cen", 128'(sram_cen), 128'(gnt == 4'b0000));
            for (int k = 0; k < 4; k++)
                if (gnt[k]) check_val("rnd_addr", 128'(sram_a), 128'(addr[k*AW +: AW]));
            if (host_pend) begin
                if (gnt[0]) begin
                    host_pend = 1'b0;
                    host_wait = 0;
                end else begin
                    host_wait++;
                end
            end
            check_val("rnd_host_wait", 128'(host_wait <= ML + 1), 128'(1));
            exp_rv = gnt & ~we;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
